// File: rtl/ps2_key_sequencer.sv
// PS/2 scancode sequencer: tracks E0/F0 prefixes, keeps per-key held flags
// and turns Space/Up/Down/Enter into game commands and strobes.
module ps2_key_sequencer #(
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_error,
    output logic       jump_held,
    output logic       duck_held,
    output logic [1:0] action,
    output logic       jump_pulse,
    output logic       start_pulse,
    output logic [7:0] last_code,
    output logic       code_valid,
    output logic       seq_error
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] COUNT_LIMIT = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    state_t        state, state_n;
    logic [CW-1:0] count, count_n;
    logic          space_h, space_n;
    logic          up_h, up_n;
    logic          down_h, down_n;
    logic          jump_recent, jump_recent_n;
    logic [1:0]    action_n;
    logic          jump_pulse_n, start_pulse_n, code_valid_n, seq_error_n;
    logic [7:0]    last_code_n;
    logic          decode_en, is_ext, is_brk;
    logic          jump_n, duck_rise;

    assign jump_held = space_h | up_h;
    assign duck_held = down_h;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            count       <= '0;
            space_h     <= 1'b0;
            up_h        <= 1'b0;
            down_h      <= 1'b0;
            jump_recent <= 1'b0;
            action      <= 2'b00;
            jump_pulse  <= 1'b0;
            start_pulse <= 1'b0;
            code_valid  <= 1'b0;
            seq_error   <= 1'b0;
            last_code   <= 8'h00;
        end else begin
            state       <= state_n;
            count       <= count_n;
            space_h     <= space_n;
            up_h        <= up_n;
            down_h      <= down_n;
            jump_recent <= jump_recent_n;
            action      <= action_n;
            jump_pulse  <= jump_pulse_n;
            start_pulse <= start_pulse_n;
            code_valid  <= code_valid_n;
            seq_error   <= seq_error_n;
            last_code   <= last_code_n;
        end
    end

    always_comb begin
        state_n       = state;
        count_n       = count;
        seq_error_n   = 1'b0;
        decode_en     = 1'b0;
        is_ext        = 1'b0;
        is_brk        = 1'b0;

        // A dropped frame always wins over a byte in the same cycle
        if (rx_error) begin
            state_n     = IDLE;
            count_n     = '0;
            seq_error_n = 1'b1;
        end else if (rx_valid) begin
            count_n = '0;
            if (rx_data == 8'hFC || rx_data == 8'hFD) begin
                seq_error_n = 1'b1;
                state_n     = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (rx_data == 8'hF0) begin
                            state_n = BRK;
                        end else if (rx_data == 8'hE0) begin
                            state_n = EXT;
                        end else if (rx_data != 8'hAA && rx_data != 8'hFA && rx_data != 8'hEE) begin
                            decode_en = 1'b1;
                        end
                    end
                    EXT: begin
                        if (rx_data == 8'hF0) begin
                            state_n = EXT_BRK;
                        end else begin
                            decode_en = 1'b1;
                            is_ext    = 1'b1;
                            state_n   = IDLE;
                        end
                    end
                    BRK, EXT_BRK: begin
                        state_n = IDLE;
                        if (rx_data == 8'hE0 || rx_data == 8'hF0) begin
                            seq_error_n = 1'b1;
                        end else begin
                            decode_en = 1'b1;
                            is_brk    = 1'b1;
                            is_ext    = (state == EXT_BRK);
                        end
                    end
                    default: state_n = IDLE;
                endcase
            end
        end else if (state != IDLE) begin
            if (count == COUNT_LIMIT) begin
                seq_error_n = 1'b1;
                state_n     = IDLE;
                count_n     = '0;
            end else begin
                count_n = count + 1'b1;
            end
        end
    end

    // Key decode, held flags, edge detection and action arbitration
    always_comb begin
        space_n       = space_h;
        up_n          = up_h;
        down_n        = down_h;
        start_pulse_n = 1'b0;
        code_valid_n  = 1'b0;
        last_code_n   = last_code;

        if (decode_en) begin
            code_valid_n = 1'b1;
            last_code_n  = rx_data;
            if (!is_ext && rx_data == 8'h29) space_n = !is_brk;
            if (!is_ext && rx_data == 8'h5A) start_pulse_n = !is_brk;
            if (is_ext && rx_data == 8'h75) up_n = !is_brk;
            if (is_ext && rx_data == 8'h72) down_n = !is_brk;
        end

        jump_n        = space_n | up_n;
        jump_pulse_n  = jump_n & ~(space_h | up_h);
        duck_rise     = down_n & ~down_h;
        jump_recent_n = jump_recent;
        if (jump_pulse_n) begin
            jump_recent_n = 1'b1;
        end else if (duck_rise) begin
            jump_recent_n = 1'b0;
        end

        action_n = 2'b00;
        if (jump_n && down_n) begin
            action_n = jump_recent_n ? 2'b01 : 2'b10;
        end else if (jump_n) begin
            action_n = 2'b01;
        end else if (down_n) begin
            action_n = 2'b10;
        end
    end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Randomized self-checking bench for ps2_key_sequencer against a prefix/held-key
// reference model that uses press timestamps for recency.
module tb_ps2_key_sequencer;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       resetN;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_error;
    logic       jump_held, duck_held, jump_pulse, start_pulse, code_valid, seq_error;
    logic [1:0] action;
    logic [7:0] last_code;

    int checkCount = 0;
    int passCount  = 0;

    bit         mExt, mBrk, mSpace, mUp, mDown;
    int         mIdle, mCycle, mJumpTime, mDuckTime;
    logic [7:0] expLast;
    logic [1:0] expAction;
    bit         expJumpPulse, expStart, expCodeValid, expSeqErr;

    ps2_key_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .resetN(resetN), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_error(rx_error), .jump_held(jump_held), .duck_held(duck_held),
        .action(action), .jump_pulse(jump_pulse), .start_pulse(start_pulse),
        .last_code(last_code), .code_valid(code_valid), .seq_error(seq_error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    endtask

    task automatic modelReset();
        mExt = 0; mBrk = 0; mSpace = 0; mUp = 0; mDown = 0;
        mIdle = 0; mJumpTime = 0; mDuckTime = 0;
        expLast = 8'h00; expAction = 2'b00;
        expJumpPulse = 0; expStart = 0; expCodeValid = 0; expSeqErr = 0;
    endtask

    task automatic modelDecode(input logic [7:0] d);
        expCodeValid = 1;
        expLast = d;
        if (!mExt && d == 8'h29) mSpace = !mBrk;
        if (!mExt && d == 8'h5A && !mBrk) expStart = 1;
        if (mExt && d == 8'h75) mUp = !mBrk;
        if (mExt && d == 8'h72) mDown = !mBrk;
        mExt = 0; mBrk = 0;
    endtask

    task automatic modelStep(input bit v, input logic [7:0] d, input bit e);
        bit oldJump, oldDuck;
        mCycle++;
        oldJump = mSpace | mUp;
        oldDuck = mDown;
        expJumpPulse = 0; expStart = 0; expCodeValid = 0; expSeqErr = 0;
        if (e) begin
            mExt = 0; mBrk = 0; mIdle = 0; expSeqErr = 1;
        end else if (v) begin
            mIdle = 0;
            if (d == 8'hFC || d == 8'hFD || (mBrk && (d == 8'hE0 || d == 8'hF0))) begin
                expSeqErr = 1; mExt = 0; mBrk = 0;
            end else if (d == 8'hF0) begin
                mBrk = 1;
            end else if (d == 8'hE0 && !mExt && !mBrk) begin
                mExt = 1;
            end else if (!mExt && !mBrk && (d == 8'hAA || d == 8'hFA || d == 8'hEE)) begin
                // keyboard status byte, ignored
            end else begin
                modelDecode(d);
            end
        end else if (mExt || mBrk) begin
            mIdle++;
            if (mIdle == T) begin
                expSeqErr = 1; mExt = 0; mBrk = 0; mIdle = 0;
            end
        end
        if ((mSpace | mUp) && !oldJump) begin
            expJumpPulse = 1;
            mJumpTime = mCycle;
        end
        if (mDown && !oldDuck) mDuckTime = mCycle;
        if ((mSpace | mUp) && mDown) expAction = (mJumpTime > mDuckTime) ? 2'b01 : 2'b10;
        else if (mSpace | mUp) expAction = 2'b01;
        else if (mDown) expAction = 2'b10;
        else expAction = 2'b00;
    endtask

    task automatic checkAll();
        checkOutput("jump_held", {7'd0, jump_held}, {7'd0, mSpace | mUp});
        checkOutput("duck_held", {7'd0, duck_held}, {7'd0, mDown});
        checkOutput("action", {6'd0, action}, {6'd0, expAction});
        checkOutput("jump_pulse", {7'd0, jump_pulse}, {7'd0, expJumpPulse});
        checkOutput("start_pulse", {7'd0, start_pulse}, {7'd0, expStart});
        checkOutput("last_code", last_code, expLast);
        checkOutput("code_valid", {7'd0, code_valid}, {7'd0, expCodeValid});
        checkOutput("seq_error", {7'd0, seq_error}, {7'd0, expSeqErr});
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic applyStimulus(input bit v, input logic [7:0] d, input bit e);
        rx_valid = v; rx_data = d; rx_error = e;
        modelStep(v, d, e);
        @(posedge clk);
        #1;
        checkAll();
        @(negedge clk);
        rx_valid = 0; rx_error = 0;
    endtask

    task automatic sendByte(input logic [7:0] d);
        applyStimulus(1, d, 0);
    endtask

    logic [7:0] pool [12];
    int pulses, strobes, errs;

    initial begin
        pool = '{8'h29, 8'h5A, 8'hE0, 8'hF0, 8'h75, 8'h72, 8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'h1C, 8'h12};
        resetN = 0; rx_valid = 0; rx_data = 8'h00; rx_error = 0;
        mCycle = 0;
        modelReset();
        #3;
        checkAll();
        @(negedge clk);
        resetN = 1;
        applyStimulus(0, 8'h00, 0);

        // Space make then break
        sendByte(8'h29);
        checkOutput("dir_space_held", {7'd0, jump_held}, 8'd1);
        checkOutput("dir_space_action", {6'd0, action}, 8'd1);
        checkOutput("dir_space_code", last_code, 8'h29);
        sendByte(8'hF0); sendByte(8'h29);
        checkOutput("dir_space_release", {6'd0, action}, 8'd0);

        // Typematic repeat: one jump pulse, three code strobes
        pulses = 0; strobes = 0;
        for (int i = 0; i < 3; i++) begin
            sendByte(8'h29);
            pulses += int'(jump_pulse);
            strobes += int'(code_valid);
        end
        checkOutput("dir_repeat_pulses", 8'(pulses), 8'd1);
        checkOutput("dir_repeat_strobes", 8'(strobes), 8'd3);
        sendByte(8'hF0); sendByte(8'h29);

        // Duck then jump: most recent press wins
        sendByte(8'hE0); sendByte(8'h72);
        checkOutput("dir_duck", {6'd0, action}, 8'd2);
        sendByte(8'h29);
        checkOutput("dir_both_jump", {6'd0, action}, 8'd1);
        sendByte(8'hF0); sendByte(8'h29);
        checkOutput("dir_duck_again", {6'd0, action}, 8'd2);
        sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h72);
        checkOutput("dir_none", {6'd0, action}, 8'd0);

        // Prefix timeout, then Enter still starts
        sendByte(8'hE0);
        errs = 0;
        for (int i = 0; i < T + 4; i++) begin
            applyStimulus(0, 8'h00, 0);
            errs += int'(seq_error);
        end
        checkOutput("dir_timeout_errs", 8'(errs), 8'd1);
        sendByte(8'h5A);
        checkOutput("dir_start", {7'd0, start_pulse}, 8'd1);

        // rx_error cancels the prefix
        sendByte(8'hE0);
        applyStimulus(0, 8'h00, 1);
        sendByte(8'h75);
        checkOutput("dir_err_unext", {7'd0, jump_held}, 8'd0);
        checkOutput("dir_err_code", last_code, 8'h75);

        // Asynchronous reset while Space is held, then reset after a prefix
        sendByte(8'h29);
        #2 resetN = 0;
        #1;
        checkOutput("dir_rst_jump", {7'd0, jump_held}, 8'd0);
        checkOutput("dir_rst_action", {6'd0, action}, 8'd0);
        checkOutput("dir_rst_code", last_code, 8'h00);
        modelReset();
        @(negedge clk);
        resetN = 1;
        sendByte(8'hE0);
        resetN = 0;
        modelReset();
        @(negedge clk);
        resetN = 1;
        sendByte(8'h75);
        sendByte(8'h29);

        // Random byte streams with occasional errors and long idle gaps
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                applyStimulus(0, 8'h00, 1);
            end else if (r < 4) begin
                for (int k = 0; k < T + int'($urandom_range(0, 3)); k++) applyStimulus(0, 8'h00, 0);
            end else if (r < 50) begin
                applyStimulus(1, pool[$urandom_range(0, 11)], ($urandom_range(0, 49) == 0));
            end else begin
                applyStimulus(0, 8'($urandom), 0);
            end
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/ps2_key_sequencer.md
PS2_KEY_SEQUENCER -- requirements
Module: ps2_key_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 2500000, max clk cycles allowed between a prefix byte and its following byte.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 resetN  input  1  asynchronous, active-low reset.
REQ-004 rx_valid  input  1  one-cycle strobe: rx_data holds a complete, parity-checked scancode byte.
REQ-005 rx_data  input  8  scancode byte, sampled only when rx_valid=1.
REQ-006 rx_error  input  1  one-cycle strobe: receiver dropped a frame (start/parity/stop fault).
REQ-007 jump_held  output  1  level: Space (0x29) or Up arrow (E0 75) currently pressed.
REQ-008 duck_held  output  1  level: Down arrow (E0 72) currently pressed.
REQ-009 action  output  2  arbitrated command: 00 none, 01 jump, 10 duck; 11 never driven.
REQ-010 jump_pulse  output  1  one-cycle strobe on a new jump press.
REQ-011 start_pulse  output  1  one-cycle strobe on Enter (0x5A) make.
REQ-012 last_code  output  8  last non-prefix code byte accepted.
REQ-013 code_valid  output  1  one-cycle strobe coincident with each last_code update.
REQ-014 seq_error  output  1  one-cycle strobe on timeout, rx_error, or BAT failure.

Function
REQ-015 FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0).
REQ-016 IDLE: F0->BRK, E0->EXT, other bytes decoded as unextended make; state stays IDLE.
REQ-017 EXT: F0->EXT_BRK; any other byte decoded as extended make, ->IDLE.
REQ-018 BRK: byte decoded as unextended break, ->IDLE; EXT_BRK: byte decoded as extended break, ->IDLE.
REQ-019 Prefix bytes E0/F0 received in BRK or EXT_BRK: seq_error pulse, state ->IDLE, byte discarded.
REQ-020 Bytes 0xAA, 0xFA, 0xEE in IDLE: ignored, no code_valid; 0xFC/0xFD in any state: seq_error, ->IDLE.
REQ-021 Decoded byte (make or break, any key incl. unmapped) updates last_code and pulses code_valid in the cycle after rx_valid.
REQ-022 Per-key held flags: space_h, up_h, down_h; set on make, clear on break; jump_held=space_h|up_h; duck_held=down_h.
REQ-023 jump_pulse fires only when jump_held transitions 0->1; typematic repeat makes of an already-held key fire nothing.
REQ-024 start_pulse fires on every Enter make, including repeats; Enter break ignored.
REQ-025 action arbitration: only one of jump/duck held -> that one; both held -> most recently pressed wins (recency flag updated on each 0->1 of jump_held or duck_held); neither -> 00.
REQ-026 All outputs registered; latency rx_valid -> held flags/action/pulses = 1 cycle.
REQ-027 Timeout counter runs only outside IDLE, clears on every rx_valid; reaching TIMEOUT_CYCLES-1 -> seq_error, ->IDLE.
REQ-028 rx_valid and timeout in same cycle: byte processed, no timeout.
REQ-029 rx_error: ->IDLE, counter cleared, seq_error pulse, held flags unchanged; rx_error with rx_valid same cycle: rx_error wins, byte dropped.
REQ-030 Extended-prefixed Space/Enter (E0 29, E0 5A) treated as distinct unmapped keys (keypad Enter does not start).

Reset
REQ-031 resetN=0 asynchronously forces: state IDLE, counter 0, all held/recency flags 0, action 00, all pulses 0, last_code 0x00.
REQ-032 Reset mid-sequence (e.g. after E0) discards the prefix; first byte after release is decoded from IDLE.

Verification
REQ-033 29 -> jump_held=1, action=01, jump_pulse 1 cycle, last_code=0x29; F0 29 -> jump_held=0, action=00.
REQ-034 29,29,29 (repeat) -> exactly one jump_pulse; three code_valid strobes.
REQ-035 E0 72, then 29 -> action 10 then 01; F0 29 -> action 10; E0 F0 72 -> action 00.
REQ-036 E0 then idle TIMEOUT_CYCLES cycles -> one seq_error pulse, state IDLE; next byte 5A -> start_pulse.
REQ-037 E0, rx_error, 75 -> seq_error, 75 decoded unextended (jump_held stays 0, last_code=0x75).
REQ-038 Hold 29, assert resetN=0 mid-cycle -> jump_held, action, last_code clear immediately without clk edge.
